// File: rtl/victim_way_select_pkg.sv
// Shared definitions for the replacement-victim selector: default geometry,
// PLRU sizing helper and the victim-source encoding.
package victim_way_select_pkg;

  localparam int unsigned DEFAULT_WAYS = 4;
  localparam int unsigned DEFAULT_SETS = 64;

  typedef enum logic [1:0] {
    SrcPlru,
    SrcInvalid,
    SrcClean
  } victim_src_e;

  // A binary tree over WAYS leaves has WAYS-1 internal nodes.
  function automatic int unsigned plru_bits(input int unsigned ways);
    return ways - 1;
  endfunction

endpackage

// File: rtl/plru_tree_pick.sv
// Combinational tree pseudo-LRU helper: walks one set's PLRU bits to the victim
// way, and computes that set's next bits for an access to touch_way.
module plru_tree_pick
  import victim_way_select_pkg::*;
#(
  parameter int unsigned WAYS      = DEFAULT_WAYS,
  parameter int unsigned WAY_W     = $clog2(WAYS),
  parameter int unsigned PLRU_BITS = plru_bits(WAYS)
) (
  input  logic [PLRU_BITS-1:0] plru,
  input  logic [WAY_W-1:0]     touch_way,
  output logic [WAY_W-1:0]     pick_way,
  output logic [PLRU_BITS-1:0] next_plru
);

  // Heap-ordered walk: each node bit selects the half holding the victim,
  // MSB of the way number first.
  always_comb begin
    int   node;
    logic bit_v;
    pick_way = '0;
    node     = 0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      bit_v = 1'b0;
      for (int k = 0; k < int'(PLRU_BITS); k++) begin
        if (node == k) bit_v = plru[k];
      end
      pick_way = (pick_way << 1) | WAY_W'(bit_v);
      node     = 2 * node + 1 + int'(bit_v);
    end
  end

  always_comb begin
    int               node;
    logic             dir;
    logic [WAY_W-1:0] way;
    next_plru = plru;
    way       = touch_way;
    node      = 0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      dir = way[WAY_W-1];
      way = way << 1;
      for (int k = 0; k < int'(PLRU_BITS); k++) begin
        if (node == k) next_plru[k] = ~dir;
      end
      node = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/victim_way_select.sv
// N-way replacement-victim selector: per-set tree PLRU state plus invalid/clean
// priority, answering one registered lookup per cycle.
module victim_way_select
  import victim_way_select_pkg::*;
#(
  parameter int unsigned WAYS         = DEFAULT_WAYS,
  parameter int unsigned SETS         = DEFAULT_SETS,
  parameter int unsigned IDX_W        = $clog2(SETS),
  parameter int unsigned WAY_W        = $clog2(WAYS),
  parameter bit          PREFER_CLEAN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             lookup,
  input  logic [IDX_W-1:0] lookup_idx,
  input  logic [WAYS-1:0]  valid,
  input  logic [WAYS-1:0]  dirty,
  input  logic             touch,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim,
  output logic             victim_ok
);

  localparam int unsigned PLRU_BITS = plru_bits(WAYS);

  logic [PLRU_BITS-1:0] plru_q [SETS];
  logic [WAY_W-1:0]     victim_q;
  logic                 victim_ok_q;

  logic [WAY_W-1:0]     plru_way, touch_pick, inv_way, clean_way, sel_way;
  logic [PLRU_BITS-1:0] lookup_next, touch_next;
  logic                 any_inv, any_clean;
  victim_src_e          src;
  logic                 unused_pick;

  plru_tree_pick #(
    .WAYS      (WAYS),
    .WAY_W     (WAY_W),
    .PLRU_BITS (PLRU_BITS)
  ) u_lookup_tree (
    .plru      (plru_q[lookup_idx]),
    .touch_way (touch_way),
    .pick_way  (plru_way),
    .next_plru (lookup_next)
  );

  plru_tree_pick #(
    .WAYS      (WAYS),
    .WAY_W     (WAY_W),
    .PLRU_BITS (PLRU_BITS)
  ) u_touch_tree (
    .plru      (plru_q[touch_idx]),
    .touch_way (touch_way),
    .pick_way  (touch_pick),
    .next_plru (touch_next)
  );

  // Each instance only feeds one of its two results into this level.
  assign unused_pick = ^{touch_pick, lookup_next};

  assign any_inv   = ~&valid;
  assign any_clean = ~&dirty;

  // Scan high to low so the lowest qualifying way wins.
  always_comb begin
    inv_way   = '0;
    clean_way = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (!valid[i]) inv_way = WAY_W'(i);
      if (!dirty[i]) clean_way = WAY_W'(i);
    end
  end

  always_comb begin
    src = SrcPlru;
    if (any_inv) begin
      src = SrcInvalid;
    end else if (PREFER_CLEAN && dirty[plru_way] && any_clean) begin
      src = SrcClean;
    end
  end

  always_comb begin
    sel_way = plru_way;
    unique case (src)
      SrcInvalid: sel_way = inv_way;
      SrcClean:   sel_way = clean_way;
      default:    sel_way = plru_way;
    endcase
  end

  // Lookup reads pre-touch state; a same-set touch commits at this same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      victim_q    <= '0;
      victim_ok_q <= 1'b0;
      for (int s = 0; s < int'(SETS); s++) begin
        plru_q[s] <= '0;
      end
    end else begin
      victim_ok_q <= enable & lookup;
      if (enable && lookup) victim_q <= sel_way;
      if (enable && touch) plru_q[touch_idx] <= touch_next;
    end
  end

  assign victim    = victim_q;
  assign victim_ok = victim_ok_q;

endmodule

// File: tb/tb_victim_way_select.sv
// Directed self-checking bench for victim_way_select (4 ways, 64 sets), with a
// second instance built without clean-way preference.
module tb_victim_way_select;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       lookup;
  logic [5:0] lookup_idx;
  logic [3:0] valid;
  logic [3:0] dirty;
  logic       touch;
  logic [5:0] touch_idx;
  logic [1:0] touch_way;
  logic [1:0] victim, victim_nc;
  logic       victim_ok, victim_ok_nc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  victim_way_select #(
    .WAYS         (4),
    .SETS         (64),
    .PREFER_CLEAN (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .lookup     (lookup),
    .lookup_idx (lookup_idx),
    .valid      (valid),
    .dirty      (dirty),
    .touch      (touch),
    .touch_idx  (touch_idx),
    .touch_way  (touch_way),
    .victim     (victim),
    .victim_ok  (victim_ok)
  );

  victim_way_select #(
    .WAYS         (4),
    .SETS         (64),
    .PREFER_CLEAN (1'b0)
  ) dut_nc (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .lookup     (lookup),
    .lookup_idx (lookup_idx),
    .valid      (valid),
    .dirty      (dirty),
    .touch      (touch),
    .touch_idx  (touch_idx),
    .touch_way  (touch_way),
    .victim     (victim_nc),
    .victim_ok  (victim_ok_nc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic drive(input logic lk, input logic [5:0] li, input logic [3:0] v,
                       input logic [3:0] d, input logic tc, input logic [5:0] ti,
                       input logic [1:0] tw);
    lookup     = lk;
    lookup_idx = li;
    valid      = v;
    dirty      = d;
    touch      = tc;
    touch_idx  = ti;
    touch_way  = tw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    drive(1'b0, 6'd0, 4'b1111, 4'b0000, 1'b0, 6'd0, 2'd0);
    tick();
    tick();
    chk("reset_victim", victim, 0);
    chk("reset_ok", victim_ok, 0);
    rst = 1'b0;

    // 1: basic lookup, then ok drops
    drive(1'b1, 6'd0, 4'b1111, 4'b0000, 1'b0, 6'd0, 2'd0);
    tick();
    chk("t1_victim", victim, 0);
    chk("t1_ok", victim_ok, 1);
    drive(1'b0, 6'd0, 4'b1111, 4'b0000, 1'b0, 6'd0, 2'd0);
    tick();
    chk("t1_ok_drop", victim_ok, 0);

    // 2: invalid way beats PLRU
    drive(1'b1, 6'd0, 4'b1011, 4'b1111, 1'b0, 6'd0, 2'd0);
    tick();
    chk("t2_victim", victim, 2);
    chk("t2_victim_nc", victim_nc, 2);

    // 3: touches steer the tree
    drive(1'b0, 6'd5, 4'b1111, 4'b0000, 1'b1, 6'd5, 2'd0);
    tick();
    chk("t3_touch_ok", victim_ok, 0);
    chk("t3_touch_hold", victim, 2);
    drive(1'b1, 6'd5, 4'b1111, 4'b0000, 1'b0, 6'd0, 2'd0);
    tick();
    chk("t3_after_way0", victim, 2);
    drive(1'b0, 6'd5, 4'b1111, 4'b0000, 1'b1, 6'd5, 2'd2);
    tick();
    drive(1'b1, 6'd5, 4'b1111, 4'b0000, 1'b0, 6'd0, 2'd0);
    tick();
    chk("t3_after_way2", victim, 1);
    drive(1'b1, 6'd6, 4'b1111, 4'b0000, 1'b0, 6'd0, 2'd0);
    tick();
    chk("t3_set6", victim, 0);

    // 4: clean preference on a fresh set
    drive(1'b1, 6'd7, 4'b1111, 4'b0011, 1'b0, 6'd0, 2'd0);
    tick();
    chk("t4_clean", victim, 2);
    chk("t4_clean_nc", victim_nc, 0);
    drive(1'b1, 6'd7, 4'b1111, 4'b1111, 1'b0, 6'd0, 2'd0);
    tick();
    chk("t4_alldirty", victim, 0);
    chk("t4_alldirty_nc", victim_nc, 0);

    // 5: same-cycle lookup and touch on set 9
    drive(1'b1, 6'd9, 4'b1111, 4'b0000, 1'b1, 6'd9, 2'd0);
    tick();
    chk("t5_old_state", victim, 0);
    chk("t5_ok", victim_ok, 1);
    drive(1'b1, 6'd9, 4'b1111, 4'b0000, 1'b0, 6'd0, 2'd0);
    tick();
    chk("t5_new_state", victim, 2);

    // 6: enable gate, then reset overriding activity
    enable = 1'b0;
    drive(1'b1, 6'd9, 4'b1110, 4'b0000, 1'b1, 6'd9, 2'd2);
    tick();
    chk("t6_dis_ok", victim_ok, 0);
    chk("t6_dis_hold", victim, 2);
    enable = 1'b1;
    drive(1'b1, 6'd9, 4'b1111, 4'b0000, 1'b0, 6'd0, 2'd0);
    tick();
    chk("t6_dis_no_touch", victim, 2);
    rst = 1'b1;
    drive(1'b1, 6'd5, 4'b1111, 4'b0000, 1'b1, 6'd5, 2'd3);
    tick();
    chk("t6_rst_victim", victim, 0);
    chk("t6_rst_ok", victim_ok, 0);
    rst = 1'b0;
    drive(1'b1, 6'd5, 4'b1111, 4'b0000, 1'b0, 6'd0, 2'd0);
    tick();
    chk("t6_rst_set5", victim, 0);
    drive(1'b1, 6'd9, 4'b1111, 4'b0000, 1'b0, 6'd0, 2'd0);
    tick();
    chk("t6_rst_set9", victim, 0);
    chk("t6_rst_ok_back", victim_ok, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
